// File: rtl/pe_mac_engine_if.sv
// Operand-load, command and result ports of one pe_mac_engine lane.
// The engine uses the slave modport and the lane controller uses the master modport.
interface pe_mac_engine_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int DEPTH  = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_sel;
  logic [DATA_W-1:0] in_data;
  logic              start;
  logic [LW-1:0]     len;
  logic              signed_mode;
  logic              sat_en;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              ovf;

  modport slave (
    input  in_valid, in_sel, in_data, start, len, signed_mode, sat_en, out_ready,
    output in_ready, busy, out_valid, out_data, ovf
  );

  modport master (
    output in_valid, in_sel, in_data, start, len, signed_mode, sat_en, out_ready,
    input  in_ready, busy, out_valid, out_data, ovf
  );
endinterface

// File: rtl/pe_mac_engine.sv
// Per-lane dot-product engine: loads operand vectors A/B, then accumulates
// one product per cycle with signed/unsigned and saturating/wrapping modes.
module pe_mac_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int DEPTH  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pe_mac_engine_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic              sgn_q, sgn_d;
  logic              sat_q, sat_d;
  logic [AW-1:0]     wpa_q, wpa_d;
  logic [AW-1:0]     wpb_q, wpb_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] mem_a_q [DEPTH];
  logic [DATA_W-1:0] mem_b_q [DEPTH];

  logic              in_fire;
  logic              out_fire;
  logic              mac_last;
  logic [LW-1:0]     len_clamp;

  logic [DATA_W-1:0]          op_a, op_b;
  logic signed [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W:0]             prod_x, acc_x, sum;

  // Overflow of the ACC_W+1-bit exact sum against the ACC_W range.
  function automatic logic sum_ovf(input logic [ACC_W:0] s, input logic sgn);
    return sgn ? (s[ACC_W] ^ s[ACC_W-1]) : s[ACC_W];
  endfunction

  function automatic logic [ACC_W-1:0] clamp_acc(input logic [ACC_W:0] s,
                                                 input logic sgn, input logic sat);
    if (!sat || !sum_ovf(s, sgn)) return s[ACC_W-1:0];
    if (!sgn) return {ACC_W{1'b1}};
    return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  assign in_fire   = bus.in_valid && (state_q == S_IDLE);
  assign out_fire  = out_valid_q && bus.out_ready;
  assign mac_last  = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign len_clamp = (bus.len > LW'(DEPTH)) ? LW'(DEPTH) : bus.len;

  // Stage: operand read, full-width product, exact ACC_W+1-bit sum
  always_comb begin
    op_a   = mem_a_q[idx_q];
    op_b   = mem_b_q[idx_q];
    a_ext  = sgn_q ? $signed({{DATA_W{op_a[DATA_W-1]}}, op_a}) : $signed({{DATA_W{1'b0}}, op_a});
    b_ext  = sgn_q ? $signed({{DATA_W{op_b[DATA_W-1]}}, op_b}) : $signed({{DATA_W{1'b0}}, op_b});
    prod   = a_ext * b_ext;
    prod_x = {{(ACC_W+1-2*DATA_W){sgn_q & prod[2*DATA_W-1]}}, prod};
    acc_x  = {sgn_q & acc_q[ACC_W-1], acc_q};
    sum    = acc_x + prod_x;
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    idx_d       = idx_q;
    len_d       = len_q;
    sgn_d       = sgn_q;
    sat_d       = sat_q;
    wpa_d       = wpa_q;
    wpb_d       = wpb_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          if (bus.in_sel) wpa_d = wpa_q + AW'(1);
          else            wpb_d = wpb_q + AW'(1);
        end
        if (bus.start) begin
          len_d   = len_clamp;
          sgn_d   = bus.signed_mode;
          sat_d   = bus.sat_en;
          acc_d   = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = (len_clamp == '0) ? S_DONE : S_MAC;
        end
      end
      S_MAC: begin
        acc_d = clamp_acc(sum, sgn_q, sat_q);
        ovf_d = ovf_q | sum_ovf(sum, sgn_q);
        idx_d = idx_q + AW'(1);
        if (mac_last) state_d = S_DONE;
      end
      S_DONE: begin
        // Result is presented one cycle after entering DONE, then held until taken.
        if (out_fire) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          wpa_d       = '0;
          wpb_d       = '0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      idx_q       <= '0;
      len_q       <= '0;
      sgn_q       <= 1'b0;
      sat_q       <= 1'b0;
      wpa_q       <= '0;
      wpb_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      sgn_q       <= sgn_d;
      sat_q       <= sat_d;
      wpa_q       <= wpa_d;
      wpb_q       <= wpb_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Operand storage keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (in_fire && !rst_i) begin
      if (bus.in_sel) mem_a_q[wpa_q] <= bus.in_data;
      else            mem_b_q[wpb_q] <= bus.in_data;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? acc_q : '0;
  assign bus.ovf       = out_valid_q & ovf_q;

endmodule
